// File: rtl/uart_tx_fifo_interface_if.sv
// Register-bus bundle for the UART TX FIFO: one-cycle read/write requests
// plus the registered read-data return path.
`timescale 1ns/1ps
interface uart_tx_fifo_interface_if;
  logic [1:0]  addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    input  read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/uart_tx_fifo_interface.sv
// Bus-writable TX FIFO drained into a UART by an IDLE/REQ/HOLD strobe FSM.
// Define UART_TX_IRQ_EN to add the IRQ_CTRL enable register and the irq output.
`timescale 1ns/1ps
module uart_tx_fifo_interface #(
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  uart_tx_fifo_interface_if.slave        bus,
  output logic [7:0]                     uart_write_data,
  output logic                           uart_write_req,
  input  logic                           uart_ready
`ifdef UART_TX_IRQ_EN
  ,
  output logic                           irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_IRQ    = 2'd2;

  generate
    if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two in 2..128");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            overflow_reg;
  logic [31:0]     read_data_reg;
  logic            read_data_valid_reg;
  logic [31:0]     read_mux;
  logic            full, empty, data_write, push, pop;
  logic            overflow_set, overflow_clear;
  logic            unused_bits;

  assign full           = (count_reg == FULL_COUNT);
  assign empty          = (count_reg == '0);
  assign data_write     = bus.write_req && (bus.addr == ADDR_DATA) && bus.byte_enable[0];
  // Fullness is judged before this cycle's pop, so a full FIFO never bypasses.
  assign push           = data_write && !full;
  assign overflow_set   = data_write && full;
  assign overflow_clear = bus.write_req && (bus.addr == ADDR_STATUS) &&
                          bus.byte_enable[0] && bus.write_data[2];
  assign unused_bits    = ^{bus.write_data[31:8], bus.byte_enable[3:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pop            = 1'b0;
    uart_write_req = 1'b0;
    case (state_reg)
      IDLE: if (!empty && uart_ready) state_next = REQ;
      REQ: begin
        uart_write_req = 1'b1;
        pop            = 1'b1;
        state_next     = HOLD;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.write_data[7:0];
  end

  assign uart_write_data = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (overflow_set)        overflow_reg <= 1'b1;
      else if (overflow_clear) overflow_reg <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (bus.write_req && (bus.addr == ADDR_IRQ) && bus.byte_enable[0])
        irq_en_reg <= bus.write_data[0];
      irq_reg <= irq_en_reg && empty;
    end
  end

  assign irq = irq_reg;
`endif

  always_comb begin
    read_mux = '0;
    case (bus.addr)
      ADDR_STATUS: begin
        read_mux[0]    = !full;
        read_mux[1]    = empty;
        read_mux[2]    = overflow_reg;
        read_mux[3]    = uart_ready;
        read_mux[15:8] = 8'(count_reg);
      end
`ifdef UART_TX_IRQ_EN
      ADDR_IRQ: read_mux[0] = irq_en_reg;
`endif
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_reg       <= '0;
      read_data_valid_reg <= 1'b0;
    end else begin
      read_data_valid_reg <= bus.read_req;
      if (bus.read_req) read_data_reg <= read_mux;
    end
  end

  assign bus.read_data       = read_data_reg;
  assign bus.read_data_valid = read_data_valid_reg;
endmodule

// File: tb/tb_uart_tx_fifo_interface.sv
// Directed bench for uart_tx_fifo_interface: register vector table plus
// hand-timed drain, overflow, wrap-around, reset and (optional) irq sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo_interface;
  localparam logic [1:0] ST = 2'd0, DA = 2'd1, IR = 2'd2, RS = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_ready;
  logic [7:0] uart_write_data;
  logic       uart_write_req;
`ifdef UART_TX_IRQ_EN
  logic       irq;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int bad_ready_pulses = 0;
  logic ready_at_edge = 1'b0;

  uart_tx_fifo_interface_if bus();

  uart_tx_fifo_interface #(.DEPTH(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .uart_write_data (uart_write_data),
    .uart_write_req  (uart_write_req),
    .uart_ready      (uart_ready)
`ifdef UART_TX_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } pulse_t;
  pulse_t pulses[$];

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    ready_at_edge <= uart_ready;
  end

  // A strobe is visible on the negedge after the IDLE->REQ edge; that edge saw ready_at_edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && uart_write_req === 1'b1) begin
      pulses.push_back('{uart_write_data, cyc});
      if (ready_at_edge !== 1'b1) bad_ready_pulses++;
    end
  end

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input bit wr, input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.be = be; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr = a; bus.write_data = d; bus.byte_enable = be; bus.write_req = 1'b1;
    @(negedge clk);
    bus.write_req = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a; bus.read_req = 1'b1;
    @(negedge clk);
    bus.read_req = 1'b0;
    check({name, " valid"}, 32'(bus.read_data_valid), 32'd1);
    check(name, bus.read_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int guard;

    reset_n = 1'b0; uart_ready = 1'b0;
    bus.addr = '0; bus.write_data = '0; bus.byte_enable = '0;
    bus.write_req = 1'b0; bus.read_req = 1'b0;

    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0003));
    vecs.push_back(mk(1, DA, 32'h11, 4'hE, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0003));
    vecs.push_back(mk(1, DA, 32'hAB11, 4'h1, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0101));
    vecs.push_back(mk(1, RS, 32'hFFFF_FFFF, 4'hF, 0));
    vecs.push_back(mk(0, RS, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, DA, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, IR, 0, 4'h0, 32'h0));
    for (int i = 2; i <= 8; i++) vecs.push_back(mk(1, DA, 32'h10 + i, 4'h1, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0800));
    vecs.push_back(mk(1, DA, 32'h19, 4'h1, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0804));
    vecs.push_back(mk(1, DA, 32'h1A, 4'hF, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0804));
    vecs.push_back(mk(1, ST, 32'h4, 4'hE, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0804));
    vecs.push_back(mk(1, ST, 32'h4, 4'h1, 0));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0800));
    vecs.push_back(mk(0, ST, 0, 4'h0, 32'h0000_0800));

    #12;
    check("reset read_data_valid", 32'(bus.read_data_valid), 32'd0);
    check("reset read_data", bus.read_data, 32'd0);
    check("reset uart_write_req", 32'(uart_write_req), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      else bus_read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    @(negedge clk);
    check("read_data_valid drops", 32'(bus.read_data_valid), 32'd0);
    check("no pulses with ready=0", pulses.size(), 0);

    // Full FIFO: DATA write lands on the same edge as the first pop and must be dropped.
    uart_ready = 1'b1;
    @(negedge clk);
    check("first strobe", 32'(uart_write_req), 32'd1);
    bus_write(DA, 32'h99, 4'h1);
    idle(30);
    check("full-pop drain count", pulses.size(), 8);
    for (int i = 0; i < 8 && i < pulses.size(); i++)
      check($sformatf("full-pop byte%0d", i), 32'(pulses[i].data), 32'h11 + i);
    bus_read_check("status after full-pop", ST, 32'h0000_000F);
    bus_write(ST, 32'h4, 4'h1);
    bus_read_check("status after clear", ST, 32'h0000_000B);
    pulses.delete();

    bus_write(DA, 32'h41, 4'h1);
    bus_write(DA, 32'h42, 4'h1);
    bus_write(DA, 32'h43, 4'h1);
    idle(15);
    check("three-byte count", pulses.size(), 3);
    for (int i = 0; i < 3 && i < pulses.size(); i++) begin
      check($sformatf("three-byte data%0d", i), 32'(pulses[i].data), 32'h41 + i);
      if (i > 0) check($sformatf("three-byte gap%0d", i), pulses[i].cyc - pulses[i-1].cyc, 3);
    end
    bus_read_check("status after three", ST, 32'h0000_000B);
    pulses.delete();

    pushed = 0;
    guard = 0;
    while (pulses.size() < 20 && guard < 3000) begin
      uart_ready = 1'($urandom_range(0, 1));
      if (pushed < 20 && (pushed - pulses.size()) < 7) begin
        bus_write(DA, 32'h60 + pushed, 4'h1);
        pushed++;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    uart_ready = 1'b1;
    idle(5);
    check("wrap count", pulses.size(), 20);
    for (int i = 0; i < 20 && i < pulses.size(); i++)
      check($sformatf("wrap byte%0d", i), 32'(pulses[i].data), 32'h60 + i);
    check("strobes only after ready", bad_ready_pulses, 0);
    bus_read_check("status after wrap", ST, 32'h0000_000B);
    pulses.delete();

    uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(DA, 32'h51 + i, 4'h1);
    uart_ready = 1'b1;
    @(negedge clk);
    check("strobe before reset", 32'(uart_write_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("strobe killed by reset", 32'(uart_write_req), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    check("no strobes after reset", pulses.size(), 1);
    bus_read_check("status after reset", ST, 32'h0000_000B);
    pulses.delete();
    bus_write(DA, 32'h77, 4'h1);
    idle(6);
    check("post-reset count", pulses.size(), 1);
    if (pulses.size() > 0) check("post-reset head", 32'(pulses[0].data), 32'h77);

`ifdef UART_TX_IRQ_EN
    uart_ready = 1'b0;
    check("irq disabled", 32'(irq), 32'd0);
    bus_write(IR, 32'h1, 4'h1);
    idle(1);
    check("irq enabled empty", 32'(irq), 32'd1);
    bus_read_check("irq_ctrl readback", IR, 32'h1);
    bus_write(DA, 32'hAA, 4'h1);
    idle(2);
    check("irq with byte queued", 32'(irq), 32'd0);
    uart_ready = 1'b1;
    idle(8);
    check("irq after drain", 32'(irq), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_interface.md
UART_TX_FIFO_INTERFACE -- requirements
Module: uart_tx_fifo_interface

Interface
REQ-001 Parameter DEPTH, default 8, meaning TX FIFO entries; SHALL be a power of two in the range 2..128.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port addr, input, 2 bits: register select; 0 = STATUS, 1 = DATA, 2 = IRQ_CTRL, 3 = reserved.
REQ-005 Port write_data, input, 32 bits: bus write data.
REQ-006 Port byte_enable, input, 4 bits: bus write byte lanes.
REQ-007 Ports write_req and read_req, input, 1 bit each: single-cycle bus requests; both never asserted in the same cycle.
REQ-008 Port read_data, output, 32 bits: registered read data.
REQ-009 Port read_data_valid, output, 1 bit: read_data qualifier.
REQ-010 Port uart_write_data, output, 8 bits: byte to the transmitter, driven from the FIFO head.
REQ-011 Port uart_write_req, output, 1 bit: single-cycle transmit strobe.
REQ-012 Port uart_ready, input, 1 bit: the transmitter can accept a byte.
REQ-013 Port irq, output, 1 bit: exists only when UART_TX_IRQ_EN is defined.

Function
REQ-014 A write to DATA with byte_enable[0]=1 SHALL push write_data[7:0] when count<DEPTH, counted before this cycle's pop.
- No same-cycle bypass when the FIFO is full.
REQ-015 A DATA write when count==DEPTH SHALL drop the byte, leave the FIFO unchanged and set the sticky overflow flag.
REQ-016 A write to DATA with byte_enable[0]=0 SHALL have no effect.
REQ-017 The drain FSM SHALL have three states: IDLE, REQ and HOLD.
- IDLE -> REQ when count>0 and uart_ready=1.
- REQ -> HOLD unconditionally.
- HOLD -> IDLE unconditionally.
REQ-018 uart_write_req SHALL be 1 exactly in state REQ, with uart_write_data equal to the head byte.
- The head SHALL pop on the REQ -> HOLD transition.
REQ-019 Because of HOLD, consecutive uart_write_req pulses SHALL be at least 3 cycles apart.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged and preserve byte order.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-022 A read_req SHALL produce read_data_valid=1 exactly one cycle later, with read_data registered in that same cycle.
REQ-023 STATUS read_data SHALL contain:
- bit0 = not full (count<DEPTH)
- bit1 = empty (count==0)
- bit2 = overflow
- bit3 = uart_ready
- bits[15:8] = count
- all other bits 0.
REQ-024 Reads of DATA and of reserved addr 3 SHALL return 0; writes to addr 3 SHALL be ignored.
REQ-025 A write to STATUS with byte_enable[0]=1 and write_data[2]=1 SHALL clear overflow.
- If an overflowing DATA write occurs in the same cycle, the set SHALL win.
REQ-026 Reads SHALL have no side effects.

Reset
REQ-027 While reset_n=0 the block SHALL immediately, and independently of clk, set:
- read_data_valid=0, read_data=0, uart_write_req=0
- FSM=IDLE, pointers=0, count=0, overflow=0, IRQ enable=0.
REQ-028 Reset asserted mid-drain SHALL discard all queued bytes and end any uart_write_req pulse at once.
REQ-029 FIFO storage need not be reset; uart_write_data is don't-care while count==0.

Configuration
REQ-030 With UART_TX_IRQ_EN defined, IRQ_CTRL bit0 SHALL be a read/write enable, written only when byte_enable[0]=1.
- irq SHALL be a registered output equal to enable AND empty, lagging by one cycle.
REQ-031 Without UART_TX_IRQ_EN, the irq port and enable register SHALL not exist.
- IRQ_CTRL SHALL read 0 and ignore writes.

Verification
REQ-032 DEPTH=8, uart_ready=1, push 0x41, 0x42, 0x43 -> three uart_write_req pulses 3 cycles apart carrying 0x41, 0x42, 0x43 in order, then count=0.
REQ-033 uart_ready=0, push 10 bytes -> first 8 accepted, STATUS reads 0x0000_0804 (count 8, overflow set); write STATUS 0x4 -> reads 0x0000_0800.
REQ-034 uart_ready=0 with count=8, then a DATA push in the same cycle as the first pop -> push dropped and overflow set; the remaining 7 bytes then drain in order.
REQ-035 Push 20 bytes with uart_ready toggling pseudo-randomly -> all 20 bytes emitted in order through pointer wrap-around; no pulse while uart_ready=0 in IDLE.
REQ-036 Assert reset_n=0 during a REQ cycle with 5 bytes queued -> uart_write_req falls the same cycle and STATUS reads 0x0000_000B with uart_ready=1 after release.
REQ-037 UART_TX_IRQ_EN defined, write IRQ_CTRL 0x1 with an empty FIFO -> irq=1; push one byte with uart_ready=0 -> irq=0; drain it -> irq=1.
